// File: rtl/branch_pkg.sv
// Shared constants and types for the branch resolution unit and its prediction queue.
package branch_pkg;

  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam int unsigned PC_INC = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  // Queue entry layout, MSB first: {taken, target, pc}
  localparam int unsigned ENTRY_TAKEN_W = 1;

  function automatic int unsigned entry_width(input int unsigned data_w);
    return ENTRY_TAKEN_W + 2 * data_w;
  endfunction

endpackage

// File: rtl/pred_queue.sv
// Synchronous FIFO holding in-flight branch predictions, with a single-cycle clear.
module pred_queue
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    // A push into a full queue is only legal when the head leaves in the same cycle.
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Resolves queued branch predictions against EX/MEM outcomes; drives predictor update, redirect and flush.
// Optional performance counters are enabled with `define BRU_PERF_COUNTERS_EN.
module branch_resolution_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned INDEX_BITS   = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  pred_valid,
  input  logic                  pred_taken,
  input  logic [DATA_WIDTH-1:0] pred_target,
  input  logic [DATA_WIDTH-1:0] pred_pc,
  input  logic                  res_valid,
  input  logic                  res_taken,
  input  logic [DATA_WIDTH-1:0] res_target,
  input  logic [DATA_WIDTH-1:0] res_pc,
  output logic                  queue_full,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  upd_en,
  output logic [INDEX_BITS-1:0] upd_idx,
  output logic                  upd_taken,
  output logic [DATA_WIDTH-1:0] upd_target,
  output logic                  protocol_err
`ifdef BRU_PERF_COUNTERS_EN
  ,
  output logic [31:0]           branch_cnt,
  output logic [31:0]           mispredict_cnt
`endif
);

  localparam int unsigned ENTRY_W = entry_width(DATA_WIDTH);
  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned FCNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bru_state_e            state_q, state_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;

  logic [ENTRY_W-1:0]    q_wdata, q_rdata;
  logic                  q_full, q_empty, q_push, q_pop, q_clr;
  logic [CNT_W-1:0]      q_count;
  logic                  head_taken;
  logic [DATA_WIDTH-1:0] head_target, head_pc;

  logic                  in_run, resolve, empty_res, pc_mismatch, mispredict;

  logic                  upd_en_q, upd_en_d;
  logic [INDEX_BITS-1:0] upd_idx_q, upd_idx_d;
  logic                  upd_taken_q, upd_taken_d;
  logic [DATA_WIDTH-1:0] upd_target_q, upd_target_d;
  logic                  redir_valid_q, redir_valid_d;
  logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic                  perr_q, perr_d;

  assign q_wdata = {pred_taken, pred_target, pred_pc};
  assign {head_taken, head_target, head_pc} = q_rdata;

  assign in_run      = (state_q == RUN);
  assign resolve     = res_valid && in_run && !q_empty;
  assign empty_res   = res_valid && in_run && q_empty;
  assign pc_mismatch = (head_pc != res_pc);
  assign mispredict  = resolve && ((head_taken != res_taken)
                                   || (res_taken && (head_target != res_target))
                                   || pc_mismatch);

  assign queue_full = (q_count == CNT_W'(QUEUE_DEPTH)) && !res_valid;
  assign q_push     = pred_valid && in_run && (!q_full || res_valid);
  assign q_pop      = resolve;
  // Entries behind a mispredicted branch are squashed, including one pushed this cycle.
  assign q_clr      = mispredict;

  pred_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_pred_queue (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (q_clr),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    flush = (state_q == FLUSH);
  end

  always_comb begin
    upd_en_d      = 1'b0;
    upd_idx_d     = '0;
    upd_taken_d   = 1'b0;
    upd_target_d  = '0;
    redir_valid_d = 1'b0;
    redir_pc_d    = '0;
    perr_d        = perr_q || empty_res || (resolve && pc_mismatch);
    if (resolve) begin
      upd_en_d     = 1'b1;
      upd_idx_d    = res_pc[INDEX_BITS-1:0];
      upd_taken_d  = res_taken;
      upd_target_d = res_target;
    end
    if (mispredict) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = res_taken ? res_target : (res_pc + DATA_WIDTH'(PC_INC));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      upd_en_q      <= 1'b0;
      upd_idx_q     <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      perr_q        <= 1'b0;
    end else begin
      upd_en_q      <= upd_en_d;
      upd_idx_q     <= upd_idx_d;
      upd_taken_q   <= upd_taken_d;
      upd_target_q  <= upd_target_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      perr_q        <= perr_d;
    end
  end

  assign upd_en         = upd_en_q;
  assign upd_idx        = upd_idx_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign protocol_err   = perr_q;

`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (resolve && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (mispredict && (mp_cnt_q != '1)) begin
      mp_cnt_d = mp_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign branch_cnt     = br_cnt_q;
  assign mispredict_cnt = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_branch_resolution_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned QD = 4;
  localparam int unsigned IB = 3;
  localparam int unsigned FC = 2;

  logic          i_clk, i_rst_n;
  logic          pred_valid, pred_taken, res_valid, res_taken;
  logic [DW-1:0] pred_target, pred_pc, res_target, res_pc;
  logic          queue_full, redirect_valid, flush, upd_en, upd_taken, protocol_err;
  logic [DW-1:0] redirect_pc, upd_target;
  logic [IB-1:0] upd_idx;
`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0]   branch_cnt, mispredict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          taken;
    logic [DW-1:0] target;
    logic [DW-1:0] pc;
  } ent_t;

  // Reference model: prediction queue, remaining visible flush cycles, sticky error and expected registered outputs.
  ent_t          m_q[$];
  int            m_flush_left;
  logic          m_err;
  logic          e_upd_en, e_upd_taken, e_redir;
  logic [IB-1:0] e_upd_idx;
  logic [DW-1:0] e_upd_target, e_redir_pc;
  logic [31:0]   m_bcnt, m_mcnt;

  branch_resolution_unit #(
    .DATA_WIDTH   (DW),
    .QUEUE_DEPTH  (QD),
    .INDEX_BITS   (IB),
    .FLUSH_CYCLES (FC)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_pc        (pred_pc),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .res_pc         (res_pc),
    .queue_full     (queue_full),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .upd_en         (upd_en),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .protocol_err   (protocol_err)
`ifdef BRU_PERF_COUNTERS_EN
    ,
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic model_clear();
    m_q.delete();
    m_flush_left = 0;
    m_err        = 1'b0;
    e_upd_en     = 1'b0;
    e_upd_taken  = 1'b0;
    e_upd_idx    = '0;
    e_upd_target = '0;
    e_redir      = 1'b0;
    e_redir_pc   = '0;
    m_bcnt       = '0;
    m_mcnt       = '0;
  endtask

  task automatic idle_inputs();
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    pred_pc     = '0;
    res_valid   = 1'b0;
    res_taken   = 1'b0;
    res_target  = '0;
    res_pc      = '0;
  endtask

  // Advance the model by one clock with the currently driven inputs, then clock the DUT.
  task automatic tick();
    logic  flushing;
    logic  accept;
    ent_t  h;
    logic  bad_pc, mis;
    flushing = (m_flush_left > 0);
    accept   = pred_valid && !flushing && ((m_q.size() < QD) || res_valid);
    e_upd_en = 1'b0;
    e_redir  = 1'b0;
    if (flushing) begin
      m_flush_left--;
    end else if (res_valid) begin
      if (m_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        h            = m_q.pop_front();
        bad_pc       = (h.pc != res_pc);
        mis          = bad_pc || (h.taken != res_taken) || (res_taken && (h.target != res_target));
        e_upd_en     = 1'b1;
        e_upd_idx    = IB'(res_pc % (1 << IB));
        e_upd_taken  = res_taken;
        e_upd_target = res_target;
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
        if (mis) begin
          e_redir      = 1'b1;
          e_redir_pc   = res_taken ? res_target : DW'(res_pc + 4);
          m_q.delete();
          accept       = 1'b0;
          m_flush_left = FC;
          if (bad_pc) m_err = 1'b1;
          if (m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
        end
      end
    end
    if (accept) m_q.push_back('{taken: pred_taken, target: pred_target, pc: pred_pc});
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL reset_queue_full got=%0b exp=0", queue_full); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid got=%0b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== '0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", flush); end
    checks++; if (upd_en !== 1'b0) begin failures++; $display("FAIL reset_upd_en got=%0b exp=0", upd_en); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL reset_protocol_err got=%0b exp=0", protocol_err); end
`ifdef BRU_PERF_COUNTERS_EN
    checks++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt); end
`endif
  endtask

  task automatic test_agree();
    pred_valid = 1'b1; pred_taken = 1'b1; pred_target = 32'h40; pred_pc = 32'h10;
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h40; res_pc = 32'h10;
    tick();
    idle_inputs();
    checks++; if (upd_en !== 1'b1) begin failures++; $display("FAIL agree_upd_en got=%0b exp=1", upd_en); end
    checks++; if (upd_idx !== 3'd0) begin failures++; $display("FAIL agree_upd_idx got=%0d exp=0", upd_idx); end
    checks++; if (upd_taken !== 1'b1 || upd_target !== 32'h40) begin failures++; $display("FAIL agree_upd_data got=%0b/%h exp=1/00000040", upd_taken, upd_target); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL agree_redirect got=%0b exp=0", redirect_valid); end
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL agree_flush got=%0b exp=0", flush); end
    tick();
    checks++; if (upd_en !== 1'b0) begin failures++; $display("FAIL agree_upd_en_drop got=%0b exp=0", upd_en); end
  endtask

  task automatic test_nt_taken();
    pred_valid = 1'b1; pred_taken = 1'b0; pred_target = 32'h0; pred_pc = 32'h24;
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h80; res_pc = 32'h24;
    tick();
    idle_inputs();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin failures++; $display("FAIL ntt_redirect got=%0b/%h exp=1/00000080", redirect_valid, redirect_pc); end
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL ntt_flush1 got=%0b exp=1", flush); end
    checks++; if (upd_en !== 1'b1 || upd_idx !== 3'd4 || upd_taken !== 1'b1) begin failures++; $display("FAIL ntt_update got=%0b/%0d/%0b exp=1/4/1", upd_en, upd_idx, upd_taken); end
    tick();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL ntt_redirect_pulse got=%0b exp=0", redirect_valid); end
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL ntt_flush2 got=%0b exp=1", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL ntt_flush_end got=%0b exp=0", flush); end
  endtask

  task automatic test_t_nt();
    pred_valid = 1'b1; pred_taken = 1'b1; pred_target = 32'h100; pred_pc = 32'h30;
    tick();
    pred_taken = 1'b0; pred_target = 32'h0; pred_pc = 32'h38;
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0; res_pc = 32'h30;
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h34) begin failures++; $display("FAIL tnt_redirect got=%0b/%h exp=1/00000034", redirect_valid, redirect_pc); end
    checks++; if (upd_taken !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL tnt_upd_flush got=%0b/%0b exp=0/1", upd_taken, flush); end
    // Resolve of the squashed younger branch and a new prediction, both during flush.
    res_pc = 32'h38;
    pred_valid = 1'b1; pred_taken = 1'b1; pred_target = 32'h500; pred_pc = 32'h60;
    tick();
    idle_inputs();
    checks++; if (upd_en !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL tnt_flush_res_ignored got=%0b/%0b exp=0/0", upd_en, redirect_valid); end
    checks++; if (protocol_err !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL tnt_flush_state got=%0b/%0b exp=0/1", protocol_err, flush); end
    tick();
  endtask

  task automatic test_full();
    logic [DW-1:0] pcs [5];
    logic [IB-1:0] idx;
    pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    for (int i = 0; i < 4; i++) begin
      pred_valid = 1'b1; pred_taken = 1'b0; pred_target = 32'h0; pred_pc = pcs[i];
      checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL full_early i=%0d got=%0b exp=0", i, queue_full); end
      tick();
    end
    pred_pc = pcs[4];
    #1;
    checks++; if (queue_full !== 1'b1) begin failures++; $display("FAIL full_at_depth got=%0b exp=1", queue_full); end
    tick();
    res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0; res_pc = pcs[0];
    #1;
    checks++; if (queue_full !== 1'b0) begin failures++; $display("FAIL full_with_pop got=%0b exp=0", queue_full); end
    tick();
    idle_inputs();
    #1;
    checks++; if (upd_en !== 1'b1 || redirect_valid !== 1'b0) begin failures++; $display("FAIL full_pop_res got=%0b/%0b exp=1/0", upd_en, redirect_valid); end
    checks++; if (queue_full !== 1'b1) begin failures++; $display("FAIL full_count_kept got=%0b exp=1", queue_full); end
    for (int i = 1; i < 5; i++) begin
      res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0; res_pc = pcs[i];
      tick();
      idx = IB'(pcs[i] % 8);
      checks++; if (upd_en !== 1'b1 || redirect_valid !== 1'b0 || upd_idx !== idx) begin failures++; $display("FAIL full_drain i=%0d got=%0b/%0b/%0d exp=1/0/%0d", i, upd_en, redirect_valid, upd_idx, idx); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_empty_resolve();
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h200; res_pc = 32'h44;
    tick();
    idle_inputs();
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL empty_err got=%0b exp=1", protocol_err); end
    checks++; if (upd_en !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL empty_side_effects got=%0b/%0b/%0b exp=0/0/0", upd_en, redirect_valid, flush); end
    tick();
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL empty_err_sticky got=%0b exp=1", protocol_err); end
  endtask

  task automatic test_reset_mid_flush();
    pred_valid = 1'b1; pred_taken = 1'b1; pred_target = 32'h200; pred_pc = 32'h50;
    tick();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b0; res_target = 32'h0; res_pc = 32'h50;
    tick();
    idle_inputs();
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rmf_flush_before got=%0b exp=1", flush); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rmf_flush_async got=%0b exp=0", flush); end
    checks++; if (protocol_err !== 1'b0 || redirect_valid !== 1'b0 || upd_en !== 1'b0) begin failures++; $display("FAIL rmf_outputs got=%0b/%0b/%0b exp=0/0/0", protocol_err, redirect_valid, upd_en); end
`ifdef BRU_PERF_COUNTERS_EN
    checks++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin failures++; $display("FAIL rmf_perf got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt); end
`endif
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_clear();
    res_valid = 1'b1; res_taken = 1'b0; res_pc = 32'h50;
    tick();
    idle_inputs();
    checks++; if (protocol_err !== 1'b1 || upd_en !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL rmf_queue_empty got=%0b/%0b/%0b exp=1/0/0", protocol_err, upd_en, flush); end
  endtask

  task automatic test_random();
    ent_t h;
    logic exp_qfull;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pred_valid  = ($urandom_range(0, 99) < 55);
      pred_taken  = 1'($urandom_range(0, 1));
      pred_target = $urandom & 32'hFFFF_FFFC;
      pred_pc     = $urandom & 32'hFFFF_FFFC;
      res_valid   = ($urandom_range(0, 99) < 40);
      if (m_q.size() != 0) begin
        h          = m_q[0];
        res_pc     = ($urandom_range(0, 19) == 0) ? ($urandom & 32'hFFFF_FFFC) : h.pc;
        res_taken  = ($urandom_range(0, 4) == 0) ? !h.taken : h.taken;
        res_target = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : h.target;
      end else begin
        res_pc     = $urandom & 32'hFFFF_FFFC;
        res_taken  = 1'($urandom_range(0, 1));
        res_target = $urandom & 32'hFFFF_FFFC;
      end
      #1;
      exp_qfull = (m_q.size() == QD) && !res_valid;
      checks++; if (queue_full !== exp_qfull) begin failures++; $display("FAIL rnd_queue_full n=%0d got=%0b exp=%0b", n, queue_full, exp_qfull); end
      tick();
      checks++; if (upd_en !== e_upd_en) begin failures++; $display("FAIL rnd_upd_en n=%0d got=%0b exp=%0b", n, upd_en, e_upd_en); end
      if (e_upd_en) begin
        checks++; if (upd_idx !== e_upd_idx || upd_taken !== e_upd_taken || upd_target !== e_upd_target) begin failures++; $display("FAIL rnd_upd_data n=%0d got=%0d/%0b/%h exp=%0d/%0b/%h", n, upd_idx, upd_taken, upd_target, e_upd_idx, e_upd_taken, e_upd_target); end
      end
      checks++; if (redirect_valid !== e_redir) begin failures++; $display("FAIL rnd_redirect n=%0d got=%0b exp=%0b", n, redirect_valid, e_redir); end
      if (e_redir) begin
        checks++; if (redirect_pc !== e_redir_pc) begin failures++; $display("FAIL rnd_redirect_pc n=%0d got=%h exp=%h", n, redirect_pc, e_redir_pc); end
      end
      checks++; if (flush !== (m_flush_left > 0)) begin failures++; $display("FAIL rnd_flush n=%0d got=%0b exp=%0b", n, flush, (m_flush_left > 0)); end
      checks++; if (protocol_err !== m_err) begin failures++; $display("FAIL rnd_protocol_err n=%0d got=%0b exp=%0b", n, protocol_err, m_err); end
`ifdef BRU_PERF_COUNTERS_EN
      checks++; if (branch_cnt !== m_bcnt || mispredict_cnt !== m_mcnt) begin failures++; $display("FAIL rnd_perf n=%0d got=%0d/%0d exp=%0d/%0d", n, branch_cnt, mispredict_cnt, m_bcnt, m_mcnt); end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    i_rst_n = 1'b1;
    model_clear();
    test_reset();
    test_agree();
    test_nt_taken();
    test_t_nt();
    test_full();
    test_empty_resolve();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
